// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// MIPS memory-access stage: owns the byte-addressed data memory, performs
// aligned byte/half/word loads (with sign or zero extension) and stores,
// forwards the ALU result and destination fields to the MA/WB register, and
// streams the whole memory out through a valid/ready dump port for the UART
// debug unit.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_ALU_rslt            effective byte address / ALU result
//   i_wr_data             store data (rt value)
//   i_flg_mem_op          1 = load
//   i_flg_mem_wr          1 = store
//   i_mem_size            00 byte, 01 half, 1x word
//   i_flg_unsigned        1 = zero-extend byte/half loads
//   i_rd, i_rt            destination candidates (passthrough)
//   i_flg_ALU_dst         destination select (passthrough)
//   o_data                extended load data (combinational)
//   o_ALU_rslt, o_rd, o_rt, o_flg_ALU_dst, o_flg_mem_op   passthroughs
//   o_addr_err            misaligned load/store (combinational)
//   o_busy                dump in progress, stores are dropped
//   i_dbg_dump            start-dump pulse
//   i_dbg_ready           debug unit accepts the presented word
//   o_dbg_valid           dump word valid
//   o_dbg_addr            word index of o_dbg_word
//   o_dbg_word            dump data
//   o_dbg_done            one-cycle pulse after the last word is accepted
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int NBITS     = 32,
    parameter int MEM_DEPTH = 32,
    parameter int ADDR_W    = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NBITS-1:0]  i_ALU_rslt,
    input  logic [NBITS-1:0]  i_wr_data,
    input  logic              i_flg_mem_op,
    input  logic              i_flg_mem_wr,
    input  logic [1:0]        i_mem_size,
    input  logic              i_flg_unsigned,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_rt,
    input  logic [1:0]        i_flg_ALU_dst,
    output logic [NBITS-1:0]  o_data,
    output logic [NBITS-1:0]  o_ALU_rslt,
    output logic [4:0]        o_rd,
    output logic [4:0]        o_rt,
    output logic [1:0]        o_flg_ALU_dst,
    output logic              o_flg_mem_op,
    output logic              o_addr_err,
    output logic              o_busy,
    input  logic              i_dbg_dump,
    input  logic              i_dbg_ready,
    output logic              o_dbg_valid,
    output logic [ADDR_W-1:0] o_dbg_addr,
    output logic [NBITS-1:0]  o_dbg_word,
    output logic              o_dbg_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MEM_DEPTH - 1);

    // Which byte lanes a store of the given size touches at the given lane.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   lane_mask = 4'b0001 << lane;
            2'b01:   lane_mask = lane[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    // Merge store data into the old word; byte/half data is replicated across
    // lanes so the mask alone picks the right position.
    function automatic logic [NBITS-1:0] merge_store(input logic [NBITS-1:0] old_word,
                                                      input logic [NBITS-1:0] data,
                                                      input logic [1:0]       size,
                                                      input logic [1:0]       lane);
        logic [NBITS-1:0] rep;
        logic [3:0]       mask;
        case (size)
            2'b00:   rep = {4{data[7:0]}};
            2'b01:   rep = {2{data[15:0]}};
            default: rep = data;
        endcase
        mask = lane_mask(size, lane);
        for (int b = 0; b < 4; b++) begin
            merge_store[8*b +: 8] = mask[b] ? rep[8*b +: 8] : old_word[8*b +: 8];
        end
    endfunction

    // Select the addressed byte/half of a word and extend it to NBITS.
    function automatic logic [NBITS-1:0] extend_load(input logic [NBITS-1:0] word,
                                                      input logic [1:0]       size,
                                                      input logic [1:0]       lane,
                                                      input logic             uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   extend_load = {{(NBITS-8){b[7] & ~uns}}, b};
            2'b01:   extend_load = {{(NBITS-16){h[15] & ~uns}}, h};
            default: extend_load = word;
        endcase
    endfunction

    logic [NBITS-1:0]  mem_r [MEM_DEPTH];
    logic [ADDR_W-1:0] idx_s;
    logic [1:0]        lane_s;
    logic              misalign_s;
    logic              store_en_s;
    logic [NBITS-1:0]  rd_word_s;
    logic [NBITS-1:0]  merged_word_s;

    state_t            state_r, state_nx_s;
    logic [ADDR_W-1:0] cnt_r, cnt_nx_s;
    logic              valid_nx_s, done_nx_s, busy_nx_s;
    logic [ADDR_W-1:0] addr_nx_s;
    logic [NBITS-1:0]  word_nx_s;
    logic [NBITS-1:0]  dump_src_s;

    // Upper address bits are ignored so out-of-range addresses alias.
    assign idx_s         = i_ALU_rslt[ADDR_W+1:2];
    assign lane_s        = i_ALU_rslt[1:0];
    assign rd_word_s     = mem_r[idx_s];
    assign merged_word_s = merge_store(rd_word_s, i_wr_data, i_mem_size, lane_s);
    assign store_en_s    = i_flg_mem_wr & ~misalign_s & ~o_busy;

    assign o_ALU_rslt    = i_ALU_rslt;
    assign o_rd          = i_rd;
    assign o_rt          = i_rt;
    assign o_flg_ALU_dst = i_flg_ALU_dst;
    assign o_flg_mem_op  = i_flg_mem_op;

    // Alignment check: halves need an even address, words a multiple of four.
    always_comb begin
        case (i_mem_size)
            2'b00:   misalign_s = 1'b0;
            2'b01:   misalign_s = lane_s[0];
            default: misalign_s = (lane_s != 2'b00);
        endcase
    end

    // Load path and error flag; data reads the pre-write word of this cycle.
    always_comb begin
        o_addr_err = (i_flg_mem_op | i_flg_mem_wr) & misalign_s;
        if (i_flg_mem_op && !misalign_s) begin
            o_data = extend_load(rd_word_s, i_mem_size, lane_s, i_flg_unsigned);
        end else begin
            o_data = '0;
        end
    end

    // Data memory: cleared on reset, written only by accepted stores.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (store_en_s) begin
            mem_r[idx_s] <= merged_word_s;
        end
    end

    // Dump FSM state and registered dump outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            o_dbg_valid <= 1'b0;
            o_dbg_addr  <= '0;
            o_dbg_word  <= '0;
            o_dbg_done  <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            o_dbg_valid <= valid_nx_s;
            o_dbg_addr  <= addr_nx_s;
            o_dbg_word  <= word_nx_s;
            o_dbg_done  <= done_nx_s;
            o_busy      <= busy_nx_s;
        end
    end

    // Dump FSM next-state: walk every word, advancing only on a handshake.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (i_dbg_dump) begin
                    state_nx_s = ST_SEND;
                    cnt_nx_s   = '0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (o_dbg_valid && i_dbg_ready) begin
                    if (cnt_r == LAST_IDX) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        cnt_nx_s = cnt_r + ADDR_W'(1);
                    end
                end else begin
                    state_nx_s = ST_SEND;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Dump outputs for the next cycle. A store landing on the same edge that
    // starts the dump must be seen in word 0, hence the bypass.
    always_comb begin
        if (store_en_s && (idx_s == cnt_nx_s)) begin
            dump_src_s = merged_word_s;
        end else begin
            dump_src_s = mem_r[cnt_nx_s];
        end
        valid_nx_s = 1'b0;
        addr_nx_s  = '0;
        word_nx_s  = '0;
        done_nx_s  = 1'b0;
        busy_nx_s  = 1'b0;
        case (state_nx_s)
            ST_SEND: begin
                valid_nx_s = 1'b1;
                addr_nx_s  = cnt_nx_s;
                word_nx_s  = dump_src_s;
                busy_nx_s  = 1'b1;
            end
            ST_DONE: begin
                done_nx_s = 1'b1;
                busy_nx_s = 1'b1;
            end
            default: begin
                busy_nx_s = 1'b0;
            end
        endcase
    end

endmodule
